// File: rtl/wmst_out_fm_trans_pkg.sv
// Shared definitions for the Avalon write-master burst builder:
// FSM encoding and beat geometry.
package wmst_out_fm_trans_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int XDW_DEF = 128;
  localparam int DW_DEF  = 32;
  localparam int LANES   = XDW_DEF / DW_DEF;
  localparam int LANE_W  = $clog2(LANES);
  localparam int BEW     = XDW_DEF / 8;
endpackage

// File: rtl/wmst_out_fm_trans_packer.sv
// Beat register: drops FIFO words into 32-bit lanes and tracks per-lane
// byte enables; enables are cleared once the beat has been accepted.
module out_fm_beat_packer
  import wmst_out_fm_trans_pkg::*;
#(
  parameter int XDW = 128,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [DW-1:0]     word_i,
  input  logic              clr_i,
  output logic [XDW-1:0]    data_o,
  output logic [XDW/8-1:0]  be_o
);
  localparam int NL = XDW / DW;

  logic [NL-1:0][DW-1:0]   data_q;
  logic [NL-1:0][DW/8-1:0] be_q;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q[l] <= '0;
        be_q[l]   <= '0;
      end else if (wr_i && lane_i == LANE_W'(l)) begin
        data_q[l] <= word_i;
        be_q[l]   <= '1;
      end else if (clr_i) begin
        be_q[l]   <= '0;
      end
    end
  end

  assign data_o = data_q;
  assign be_o   = be_q;
endmodule

// File: rtl/wmst_out_fm_trans.sv
// Avalon-MM write master: drains a FWFT store FIFO into one burst of
// XDW-wide beats starting at a word-aligned byte address.
module wmst_out_fm_trans
  import wmst_out_fm_trans_pkg::*;
#(
  parameter int XAW = 32,
  parameter int XDW = 128,
  parameter int DW  = 32,
  parameter int CW  = 16,
  parameter int BW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store_trans_start,
  input  logic [XAW-1:0]   param_waddr,
  input  logic [CW-1:0]    param_iolen,
  output logic             store_trans_done,
  input  logic             store_fifo_empty,
  input  logic [DW-1:0]    store_fifo_dout,
  output logic             store_fifo_rd,
  output logic [XAW-1:0]   avm_address,
  output logic             avm_write,
  output logic [XDW-1:0]   avm_writedata,
  output logic [XDW/8-1:0] avm_byteenable,
  output logic [BW-1:0]    avm_burstcount,
  input  logic             avm_waitrequest
);
  state_e            state_q, state_d;
  logic [XAW-1:4]    waddr_q, waddr_d;
  logic [CW-1:0]     words_q, words_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [CW+1:0]     span;
  logic              pop, accept;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^param_waddr[1:0];

  assign pop    = (state_q == S_LOAD) && !store_fifo_empty;
  assign accept = (state_q == S_WRITE) && !avm_waitrequest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      words_q <= '0;
      lane_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      words_q <= words_d;
      lane_q  <= lane_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    words_d = words_q;
    lane_d  = lane_q;
    bcnt_d  = bcnt_q;
    // words spanned from lane 0 of the first beat, rounded up to whole beats
    span    = {{CW{1'b0}}, param_waddr[3:2]} + {2'b00, param_iolen} + (CW+2)'(3);
    case (state_q)
      S_IDLE: begin
        if (store_trans_start) begin
          waddr_d = param_waddr[XAW-1:4];
          words_d = param_iolen;
          lane_d  = param_waddr[3:2];
          bcnt_d  = BW'(span >> 2);
          state_d = (param_iolen == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (pop) begin
          lane_d  = lane_q + 1'b1;
          words_d = words_q - 1'b1;
          if (lane_q == LANE_W'(LANES - 1) || words_q == CW'(1))
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          lane_d  = '0;
          state_d = (words_q != '0) ? S_LOAD : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  out_fm_beat_packer #(.XDW(XDW), .DW(DW)) u_packer (
    .clk    (clk),
    .rst    (rst),
    .wr_i   (pop),
    .lane_i (lane_q),
    .word_i (store_fifo_dout),
    .clr_i  (accept),
    .data_o (avm_writedata),
    .be_o   (avm_byteenable)
  );

  assign store_fifo_rd    = pop;
  assign avm_write        = (state_q == S_WRITE);
  assign store_trans_done = (state_q == S_DONE);
  assign avm_address      = {waddr_q, 4'b0000};
  assign avm_burstcount   = bcnt_q;
endmodule

// File: tb/tb_wmst_out_fm_trans.sv
// Bench: FIFO/slave model plus a beat-level expectation queue built from
// the address/length rules, checked every cycle by one monitor.
module tb_wmst_out_fm_trans;
  localparam int XAW = 32, XDW = 128, DW = 32, CW = 16, BW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             store_trans_start = 1'b0;
  logic [XAW-1:0]   param_waddr = '0;
  logic [CW-1:0]    param_iolen = '0;
  logic             store_trans_done;
  logic             store_fifo_empty = 1'b1;
  logic [DW-1:0]    store_fifo_dout = '0;
  logic             store_fifo_rd;
  logic [XAW-1:0]   avm_address;
  logic             avm_write;
  logic [XDW-1:0]   avm_writedata;
  logic [XDW/8-1:0] avm_byteenable;
  logic [BW-1:0]    avm_burstcount;
  logic             avm_waitrequest = 1'b0;

  wmst_out_fm_trans #(.XAW(XAW), .XDW(XDW), .DW(DW), .CW(CW), .BW(BW)) dut (
    .clk(clk), .rst(rst),
    .store_trans_start(store_trans_start), .param_waddr(param_waddr),
    .param_iolen(param_iolen), .store_trans_done(store_trans_done),
    .store_fifo_empty(store_fifo_empty), .store_fifo_dout(store_fifo_dout),
    .store_fifo_rd(store_fifo_rd), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [XDW-1:0]   data;
    logic [XDW/8-1:0] be;
  } beat_t;

  int checks = 0, failures = 0;
  logic [DW-1:0]    fifo_q[$];
  beat_t            exp_q[$];
  logic [XDW/8-1:0] be_log[$];
  logic [XAW-1:0]   exp_addr, last_addr;
  int exp_bc, last_bc, start_cyc, last_acc_cyc, done_cnt, beats_acc, pops, txn;
  int stall_after = -1, stall_left = 0, wait_beat = -1, wait_left = 0;
  bit pop_now, prev_wait, prev_done;
  logic [XDW-1:0]   prev_data, mask;
  logic [XDW/8-1:0] prev_be;
  logic [XAW-1:0]   prev_addr;
  beat_t e;

  task automatic chk(input string name, input logic [XDW-1:0] act, input logic [XDW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic update_fifo_outs();
    store_fifo_empty = (fifo_q.size() == 0) || (stall_left > 0);
    store_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // Expected beats come straight from the placement rule: word i lands in
  // lane (waddr[3:2] + i) mod 4 of beat (waddr[3:2] + i) / 4.
  task automatic run_start(input logic [XAW-1:0] waddr, input int iolen);
    beat_t cur;
    int lane;
    txn++;
    exp_q.delete(); be_log.delete();
    cur = '0;
    lane = int'(waddr[3:2]);
    for (int i = 0; i < iolen; i++) begin
      logic [DW-1:0] w;
      w = 32'hC0DE_0000 + (txn << 8) + i;
      fifo_q.push_back(w);
      cur.data[lane*DW +: DW] = w;
      cur.be[lane*4 +: 4] = 4'hF;
      lane++;
      if (lane == 4 || i == iolen - 1) begin
        exp_q.push_back(cur);
        cur = '0;
        lane = 0;
      end
    end
    exp_bc = exp_q.size();
    exp_addr = waddr & ~32'hF;
    beats_acc = 0;
    update_fifo_outs();
    @(posedge clk); #2;
    store_trans_start = 1'b1; param_waddr = waddr; param_iolen = CW'(iolen);
    start_cyc = cyc;
    @(posedge clk); #2;
    store_trans_start = 1'b0; param_waddr = 32'hDEAD_BEE4; param_iolen = 16'd7;
  endtask

  task automatic wait_done();
    int d0, t;
    d0 = done_cnt; t = 0;
    while (done_cnt == d0 && t < 3000) begin @(posedge clk); t++; end
    chk("done_seen", 128'(done_cnt > d0), 128'd1);
    chk("fifo_drained", 128'(fifo_q.size()), 128'd0);
    chk("all_beats", 128'(exp_q.size()), 128'd0);
    repeat (2) @(posedge clk);
  endtask

  // Monitor + FIFO/slave driver
  initial forever begin
    @(negedge clk);
    pop_now = 1'b0;
    if (rst) begin
      prev_wait = 1'b0; prev_done = 1'b0;
    end else begin
      chk("rd_while_empty", 128'(store_fifo_rd & store_fifo_empty), 128'd0);
      if (stall_left > 0) chk("write_in_stall", 128'(avm_write), 128'd0);
      if (avm_write) begin
        chk("addr", 128'(avm_address), 128'(exp_addr));
        chk("burstcount", 128'(avm_burstcount), 128'(exp_bc));
        if (prev_wait) begin
          chk("hold_data", avm_writedata, prev_data);
          chk("hold_be", 128'(avm_byteenable), 128'(prev_be));
          chk("hold_addr", 128'(avm_address), 128'(prev_addr));
        end
        if (!avm_waitrequest) begin
          if (exp_q.size() == 0) chk("extra_beat", 128'd1, 128'd0);
          else begin
            e = exp_q.pop_front();
            for (int b = 0; b < XDW/8; b++) mask[b*8 +: 8] = {8{e.be[b]}};
            chk("beat_be", 128'(avm_byteenable), 128'(e.be));
            chk("beat_data", avm_writedata & mask, e.data);
          end
          be_log.push_back(avm_byteenable);
          last_addr = avm_address; last_bc = int'(avm_burstcount);
          beats_acc++; last_acc_cyc = cyc;
        end else if (wait_left > 0) wait_left--;
        prev_wait = avm_waitrequest;
        prev_data = avm_writedata; prev_be = avm_byteenable; prev_addr = avm_address;
      end else prev_wait = 1'b0;
      if (store_trans_done) begin
        done_cnt++;
        chk("done_after_beats", 128'(exp_q.size()), 128'd0);
        chk("done_timing", 128'(cyc), 128'(exp_bc == 0 ? start_cyc + 1 : last_acc_cyc + 1));
        chk("done_one_cycle", 128'(prev_done), 128'd0);
      end
      prev_done = store_trans_done;
      pop_now = store_fifo_rd && !store_fifo_empty;
    end
    @(posedge clk); #1;
    if (pop_now && !rst && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
      if (pops == stall_after) stall_left = 5;
      else if (stall_left > 0) stall_left--;
    end else if (stall_left > 0) stall_left--;
    avm_waitrequest = (beats_acc == wait_beat) && (wait_left > 0);
    update_fifo_outs();
  end

  initial begin
    #1;
    chk("rst_write", 128'(avm_write), 128'd0);
    chk("rst_rd", 128'(store_fifo_rd), 128'd0);
    chk("rst_done", 128'(store_trans_done), 128'd0);
    chk("rst_addr", 128'(avm_address), 128'd0);
    chk("rst_bc", 128'(avm_burstcount), 128'd0);
    chk("rst_be", 128'(avm_byteenable), 128'd0);
    chk("rst_data", avm_writedata, 128'd0);
    repeat (2) @(posedge clk); #2 rst = 1'b0;

    // zero-length transfer: no writes, immediate done
    run_start(32'h0000_0040, 0); wait_done();
    chk("zero_len_beats", 128'(beats_acc), 128'd0);

    // aligned 8 words: two full beats
    run_start(32'h0000_0100, 8); wait_done();
    chk("a8_nbeats", 128'(be_log.size()), 128'd2);
    chk("a8_be0", 128'(be_log[0]), 128'h FFFF);
    chk("a8_be1", 128'(be_log[1]), 128'h FFFF);
    chk("a8_addr", 128'(last_addr), 128'h100);
    chk("a8_bc", 128'(last_bc), 128'd2);

    // offset start, partial first and last beats
    run_start(32'h0000_0108, 3); wait_done();
    chk("u3_nbeats", 128'(be_log.size()), 128'd2);
    chk("u3_be0", 128'(be_log[0]), 128'h FF00);
    chk("u3_be1", 128'(be_log[1]), 128'h 000F);
    chk("u3_bc", 128'(last_bc), 128'd2);

    // 14 words with 3 stall cycles on beat 1, plus a start that must be ignored
    wait_beat = 1; wait_left = 3;
    run_start(32'h0000_0200, 14);
    repeat (3) @(posedge clk);
    #2 store_trans_start = 1'b1; param_waddr = 32'h0000_0990; param_iolen = 16'd0;
    @(posedge clk); #2 store_trans_start = 1'b0;
    wait_done();
    wait_beat = -1;
    chk("w14_nbeats", 128'(be_log.size()), 128'd4);
    chk("w14_be3", 128'(be_log[3]), 128'h 00FF);
    chk("w14_bc", 128'(last_bc), 128'd4);

    // FIFO runs dry for 5 cycles in the middle of a beat
    stall_after = pops + 2;
    run_start(32'h0000_0300, 10); wait_done();
    stall_after = -1;
    chk("st_nbeats", 128'(be_log.size()), 128'd3);

    // start in lane 3
    run_start(32'h0000_040C, 6); wait_done();
    chk("l3_be0", 128'(be_log[0]), 128'h F000);
    chk("l3_be2", 128'(be_log[2]), 128'h 000F);
    chk("l3_bc", 128'(last_bc), 128'd3);

    // reset while a beat is stuck in WRITE
    wait_beat = 0; wait_left = 100000;
    run_start(32'h0000_0500, 4);
    for (int t = 0; t < 50 && !avm_write; t++) @(negedge clk);
    chk("pre_rst_write", 128'(avm_write), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_write", 128'(avm_write), 128'd0);
    chk("mid_rst_rd", 128'(store_fifo_rd), 128'd0);
    chk("mid_rst_addr", 128'(avm_address), 128'd0);
    chk("mid_rst_be", 128'(avm_byteenable), 128'd0);
    fifo_q.delete(); exp_q.delete();
    wait_left = 0; wait_beat = -1;
    update_fifo_outs();
    @(posedge clk); #2 rst = 1'b0;
    avm_waitrequest = 1'b0;
    run_start(32'h0000_0604, 5); wait_done();
    chk("post_rst_nbeats", 128'(be_log.size()), 128'd2);
    chk("post_rst_be0", 128'(be_log[0]), 128'h FFF0);
    chk("post_rst_be1", 128'(be_log[1]), 128'h 00FF);

    chk("done_total", 128'(done_cnt), 128'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
